sram_cache_ctrl: RTL and testbench
==================================

Name: sram_cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller between the MEM stage and the 16-bit SRAM controller.
- Serves read hits in the same cycle. On a read miss, sequences the SRAM controller for a 64-bit line fill.
- Forwards all writes to SRAM.
- Its `ready` output is the pipeline freeze signal: high means stall.

Parameters:
- INDEX_W, 6, set index width (2^INDEX_W lines of 64 bits).
- TAG_W, 10, tag width; tag = address[3+INDEX_W+TAG_W-1 : 3+INDEX_W].

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- mem_rd_en  input  1  CPU read request
- mem_wr_en  input  1  CPU write request
- address  input  32  CPU byte address, word-aligned; bit[2] selects word in line, bits[2+INDEX_W:3] select index
- write_data  input  32  CPU write data
- read_data  output  32  CPU read data, valid when ready=0 with mem_rd_en=1
- ready  output  1  1 = freeze pipeline, request not yet complete
- sram_rd_en  output  1  line-read request to SRAM controller
- sram_wr_en  output  1  word-write request to SRAM controller
- sram_address  output  32  halfword address to SRAM controller
- sram_write_data  output  32  word to SRAM controller
- sram_read_data  input  64  line from SRAM controller; [31:0]=word 0 (lower address), [63:32]=word 1
- sram_ready  input  1  SRAM controller busy: high while operation in progress; low with en high marks the completion cycle

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE; all valid bits 0.
  - sram_rd_en=0, sram_wr_en=0, sram_address=0, sram_write_data=0.
  - Tag/data arrays are not reset.
- Storage: per line a valid bit, TAG_W tag and 64-bit data.
  - hit = valid[idx] && tag[idx]==addr_tag.
- Priority: if mem_wr_en and mem_rd_en are both high, the write is served and the read is ignored.
- States:
  - IDLE:
    - mem_wr_en -> WRITE; register sram_address={1'b0,address[31:1]}, sram_write_data=write_data.
    - else mem_rd_en && !hit -> RD_MISS; register sram_address={1'b0,address[31:3],2'b00}.
    - else stay.
  - RD_MISS: sram_rd_en=1.
    - When sram_ready==0: write sram_read_data into data[idx], set tag[idx], set valid[idx]=1, go to IDLE.
  - WRITE: sram_wr_en=1.
    - When sram_ready==0: if hit, update word address[2] of data[idx] with write_data; go to IDLE.
- sram_rd_en / sram_wr_en are decoded from the state register only. They drop in the cycle after completion, so the SRAM controller never restarts.
- ready (combinational):
  - 0 if no request.
  - 0 in IDLE on a read hit (no write pending).
  - 0 in RD_MISS/WRITE during the completion cycle (sram_ready==0).
  - 1 otherwise, including the IDLE cycle that detects a miss or write.
- read_data:
  - IDLE: word address[2] of data[idx].
  - RD_MISS completion: word address[2] of sram_read_data (forwarded).
  - Otherwise don't-care; drive 0.
- Latency:
  - Read hit: 0 stall cycles.
  - Read miss / write: 1 + SRAM controller duration (completion included).
- CPU inputs are held stable while ready=1; the controller uses the live address for hit/index lookups.
- Write to a non-present line leaves the cache unchanged (no allocate).
- Reset mid-operation: state returns to IDLE and enables drop next cycle; any in-flight fill is discarded and valid bits are cleared.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0]. Both reset to 0 and wrap at 2^32.
  - hit_count increments once per read accepted in IDLE as a hit.
  - miss_count increments once per IDLE->RD_MISS transition.
  - Writes are not counted.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then read 0x0000_0040 -> ready=1; next cycle sram_rd_en=1, sram_address=0x0000_0020. Model returns sram_ready=0 with sram_read_data=0x2222_2222_1111_1111 -> ready=0, read_data=0x1111_1111; next cycle sram_rd_en=0.
- Read 0x0000_0044 after previous fill -> same-cycle ready=0, read_data=0x2222_2222, no sram_rd_en.
- Write 0x0000_0044 data 0xDEAD_BEEF (line present) -> sram_wr_en=1, sram_address=0x0000_0022, sram_write_data=0xDEAD_BEEF. After completion, read 0x44 hits with 0xDEAD_BEEF.
- Read 0x0000_0240 (same index 8, different tag) -> miss and refill. Then read 0x40 -> miss again (conflict eviction).
- Write to a never-read address 0x0000_0100, then read it -> the read misses (no allocate). Also assert mem_rd_en and mem_wr_en together -> only sram_wr_en is issued.
- Assert rst during RD_MISS -> next cycle sram_rd_en=0 and state IDLE; a prior hit address now misses. With CACHE_STATS_EN: hit_count=0, miss_count=0.

Source files
------------

// File: rtl/sram_cache_ctrl.sv
// sram_cache_ctrl
// Direct-mapped, write-through, no-write-allocate cache between the MEM stage
// and a 16-bit SRAM controller. Each line is 64 bits and holds two CPU words.
// Read hits are served in the same cycle. A read miss fetches the whole line
// from the SRAM controller. Every write is passed through to SRAM.
//
// Optional build macro: CACHE_STATS_EN adds the hit_count and miss_count outputs.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   mem_rd_en/mem_wr_en CPU request. A write wins when both are high.
//   address, write_data CPU word-aligned byte address and write data
//   read_data           CPU read data, valid when ready=0 and mem_rd_en=1
//   ready               pipeline freeze: 1 means the request is not yet complete
//   sram_rd_en          line-read request to the SRAM controller
//   sram_wr_en          word-write request to the SRAM controller
//   sram_address        halfword address to the SRAM controller
//   sram_write_data     word sent to the SRAM controller
//   sram_read_data      line returned by the SRAM controller ([31:0] = lower word)
//   sram_ready          SRAM busy. Low while an enable is high marks completion.
//   hit_count/miss_count (CACHE_STATS_EN only) read-hit and line-fill counters
module sram_cache_ctrl #(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned TAG_W   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [63:0] sram_read_data,
  input  logic        sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned LINES  = 1 << INDEX_W;
  localparam int unsigned TAG_LO = 3 + INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WRITE
  } state_t;

  state_t state, next_state;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [63:0]      data_mem [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   addr_tag;
  logic               word_sel;
  logic               hit;
  logic [63:0]        cur_line;

  logic fill_we;
  logic wr_hit_we;
  logic accept_hit;
  logic start_miss;
  logic start_write;

  // Byte-lane bit 0 is never needed: halfword SRAM addressing drops it.
  logic unused_addr_bit;
  assign unused_addr_bit = address[0];

  assign idx      = address[2+INDEX_W:3];
  assign addr_tag = address[TAG_LO+TAG_W-1:TAG_LO];
  assign word_sel = address[2];
  assign cur_line = data_mem[idx];
  assign hit      = valid[idx] && (tag_mem[idx] == addr_tag);

  assign sram_rd_en = (state == RD_MISS);
  assign sram_wr_en = (state == WRITE);

  always_comb begin
    next_state  = state;
    ready       = 1'b0;
    read_data   = '0;
    fill_we     = 1'b0;
    wr_hit_we   = 1'b0;
    accept_hit  = 1'b0;
    start_miss  = 1'b0;
    start_write = 1'b0;
    unique case (state)
      IDLE: begin
        read_data = word_sel ? cur_line[63:32] : cur_line[31:0];
        if (mem_wr_en) begin
          next_state  = WRITE;
          start_write = 1'b1;
          ready       = 1'b1;
        end else if (mem_rd_en) begin
          if (hit) begin
            accept_hit = 1'b1;
          end else begin
            next_state = RD_MISS;
            start_miss = 1'b1;
            ready      = 1'b1;
          end
        end
      end
      RD_MISS: begin
        if (!sram_ready) begin
          // Completion cycle: install the line and forward the requested word.
          fill_we    = 1'b1;
          next_state = IDLE;
          read_data  = word_sel ? sram_read_data[63:32] : sram_read_data[31:0];
        end else begin
          ready = 1'b1;
        end
      end
      WRITE: begin
        if (!sram_ready) begin
          wr_hit_we  = hit;
          next_state = IDLE;
        end else begin
          ready = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    if (!mem_rd_en && !mem_wr_en) ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      valid           <= '0;
      sram_address    <= '0;
      sram_write_data <= '0;
    end else begin
      state <= next_state;
      if (fill_we) valid[idx] <= 1'b1;
      if (start_write) begin
        sram_address    <= {1'b0, address[31:1]};
        sram_write_data <= write_data;
      end else if (start_miss) begin
        sram_address <= {1'b0, address[31:3], 2'b00};
      end
    end
  end

  // Tag and data arrays have no reset. A fill that is in flight during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_we) begin
        data_mem[idx] <= sram_read_data;
        tag_mem[idx]  <= addr_tag;
      end else if (wr_hit_we) begin
        if (word_sel) data_mem[idx][63:32] <= write_data;
        else          data_mem[idx][31:0]  <= write_data;
      end
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (accept_hit) hit_count  <= hit_count + 32'd1;
      if (start_miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_cache_ctrl.sv
// tb_sram_cache_ctrl
// Self-checking bench for sram_cache_ctrl. The SRAM controller model uses a
// word-addressed memory and takes LAT busy cycles before its completion cycle.
// When a read is issued, the expected CPU read data is pushed to a queue. It is
// popped and compared once the controller releases ready.
module tb_sram_cache_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        sram_rd_en, sram_wr_en;
  logic [31:0] sram_address, sram_write_data;
  logic [63:0] sram_read_data;
  logic        sram_ready;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int chk_cnt  = 0;
  int fail_cnt = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  logic [31:0] sb_q[$];
  logic [31:0] mem[logic [31:0]];

  always #5 clk = ~clk;

  sram_cache_ctrl #(.INDEX_W(6), .TAG_W(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_rd_en      (mem_rd_en),
    .mem_wr_en      (mem_wr_en),
    .address        (address),
    .write_data     (write_data),
    .read_data      (read_data),
    .ready          (ready),
    .sram_rd_en     (sram_rd_en),
    .sram_wr_en     (sram_wr_en),
    .sram_address   (sram_address),
    .sram_write_data(sram_write_data),
    .sram_read_data (sram_read_data),
    .sram_ready     (sram_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  // SRAM controller model: busy for LAT cycles, then one completion cycle.
  int busy_cnt = 0;
  logic sram_en;
  logic [31:0] sram_byte;
  assign sram_en    = sram_rd_en | sram_wr_en;
  assign sram_ready = sram_en && (busy_cnt < LAT);
  assign sram_byte  = {sram_address[30:0], 1'b0};

  always @(posedge clk) begin
    if (sram_wr_en && busy_cnt == LAT) mem[{sram_byte[31:2], 2'b00}] = sram_write_data;
    if (!sram_en) busy_cnt <= 0;
    else if (busy_cnt < LAT) busy_cnt <= busy_cnt + 1;
  end

  initial sram_read_data = '0;
  always @(negedge clk)
    sram_read_data = {rd_word({sram_byte[31:3], 3'b100}), rd_word({sram_byte[31:3], 3'b000})};

  task automatic cpu_read(input logic [31:0] a, input bit exp_hit);
    int stalls = 0;
    bit done = 0;
    logic [31:0] exp;
    logic [31:0] exp_sa;
    exp_sa = {1'b0, a[31:3], 2'b00};
    @(posedge clk); #1;
    address = a; mem_rd_en = 1'b1; mem_wr_en = 1'b0;
    sb_q.push_back(rd_word({a[31:2], 2'b00}));
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (ready === 1'b0) begin
        done = 1;
        exp = sb_q.pop_front();
        chk_cnt++;
        if (read_data !== exp) begin
          fail_cnt++;
          $display("FAIL rd_data @%h: got %h expected %h", a, read_data, exp);
        end
        chk_cnt++;
        if (stalls != (exp_hit ? 0 : 1 + LAT)) begin
          fail_cnt++;
          $display("FAIL rd_stalls @%h: got %0d expected %0d", a, stalls, exp_hit ? 0 : 1 + LAT);
        end
        chk_cnt++;
        if (sram_rd_en !== !exp_hit) begin
          fail_cnt++;
          $display("FAIL rd_done_en @%h: got %b expected %b", a, sram_rd_en, !exp_hit);
        end
      end else begin
        chk_cnt++;
        if (stalls == 0 && sram_rd_en !== 1'b0) begin
          fail_cnt++;
          $display("FAIL rd_detect_en @%h: got %b expected 0", a, sram_rd_en);
        end else if (stalls > 0 && (sram_rd_en !== 1'b1 || sram_wr_en !== 1'b0 || sram_address !== exp_sa)) begin
          fail_cnt++;
          $display("FAIL rd_fill_req @%h: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=%h",
                   a, sram_rd_en, sram_wr_en, sram_address, exp_sa);
        end
        stalls++;
      end
    end
    if (!done) begin
      chk_cnt++; fail_cnt++;
      $display("FAIL rd_timeout @%h: got ready=1 for 20 cycles expected 0", a);
      sb_q.delete();
    end
    if (exp_hit) exp_hits++; else exp_misses++;
    @(posedge clk); #1;
    mem_rd_en = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (sram_rd_en !== 1'b0) begin
      fail_cnt++;
      $display("FAIL rd_en_drop @%h: got %b expected 0", a, sram_rd_en);
    end
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input bit with_rd);
    int stalls = 0;
    bit done = 0;
    logic [31:0] exp_sa;
    exp_sa = {1'b0, a[31:1]};
    @(posedge clk); #1;
    address = a; write_data = d; mem_wr_en = 1'b1; mem_rd_en = with_rd;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (ready === 1'b0) begin
        done = 1;
        chk_cnt++;
        if (stalls != 1 + LAT || sram_wr_en !== 1'b1) begin
          fail_cnt++;
          $display("FAIL wr_done @%h: got stalls=%0d wr=%b expected stalls=%0d wr=1", a, stalls, sram_wr_en, 1 + LAT);
        end
      end else begin
        chk_cnt++;
        if (stalls == 0 && (sram_wr_en !== 1'b0 || sram_rd_en !== 1'b0)) begin
          fail_cnt++;
          $display("FAIL wr_detect_en @%h: got rd=%b wr=%b expected 0 0", a, sram_rd_en, sram_wr_en);
        end else if (stalls > 0 && (sram_wr_en !== 1'b1 || sram_rd_en !== 1'b0 ||
                                    sram_address !== exp_sa || sram_write_data !== d)) begin
          fail_cnt++;
          $display("FAIL wr_req @%h: got rd=%b wr=%b addr=%h data=%h expected rd=0 wr=1 addr=%h data=%h",
                   a, sram_rd_en, sram_wr_en, sram_address, sram_write_data, exp_sa, d);
        end
        stalls++;
      end
    end
    if (!done) begin
      chk_cnt++; fail_cnt++;
      $display("FAIL wr_timeout @%h: got ready=1 for 20 cycles expected 0", a);
    end
    @(posedge clk); #1;
    mem_wr_en = 1'b0; mem_rd_en = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (sram_wr_en !== 1'b0) begin
      fail_cnt++;
      $display("FAIL wr_en_drop @%h: got %b expected 0", a, sram_wr_en);
    end
  endtask

  task automatic test_stats;
`ifdef CACHE_STATS_EN
    chk_cnt++;
    if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
      fail_cnt++;
      $display("FAIL stats: got hits=%0d misses=%0d expected hits=%0d misses=%0d",
               hit_count, miss_count, exp_hits, exp_misses);
    end
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_rd_en = 1'b0; mem_wr_en = 1'b0; address = '0; write_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (ready !== 1'b0 || sram_rd_en !== 1'b0 || sram_wr_en !== 1'b0 ||
        sram_address !== 32'h0 || sram_write_data !== 32'h0) begin
      fail_cnt++;
      $display("FAIL reset_outputs: got ready=%b rd=%b wr=%b addr=%h data=%h expected all 0",
               ready, sram_rd_en, sram_wr_en, sram_address, sram_write_data);
    end
    exp_hits = 0; exp_misses = 0;
    test_stats();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_miss_fill;
    cpu_read(32'h0000_0040, 1'b0);
  endtask

  task automatic test_hit;
    cpu_read(32'h0000_0044, 1'b1);
  endtask

  task automatic test_write_hit;
    cpu_write(32'h0000_0044, 32'hDEAD_BEEF, 1'b0);
    cpu_read(32'h0000_0044, 1'b1);
    cpu_read(32'h0000_0040, 1'b1);
  endtask

  task automatic test_conflict;
    cpu_read(32'h0000_0240, 1'b0);
    cpu_read(32'h0000_0244, 1'b1);
    cpu_read(32'h0000_0040, 1'b0);
    cpu_read(32'h0000_0044, 1'b1);
  endtask

  task automatic test_no_allocate;
    cpu_write(32'h0000_0100, 32'h1234_5678, 1'b0);
    cpu_read(32'h0000_0100, 1'b0);
    cpu_write(32'h0000_0300, 32'h0BAD_F00D, 1'b1);
    cpu_read(32'h0000_0300, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 0) ? 32'h0000_0040 : 32'h0000_0044;
      cpu_read(a, 1'b1);
    end
  endtask

  task automatic test_reset_mid_fill;
    @(posedge clk); #1;
    address = 32'h0000_0240; mem_rd_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if (sram_rd_en !== 1'b1) begin
      fail_cnt++;
      $display("FAIL mid_fill_en: got %b expected 1", sram_rd_en);
    end
    @(posedge clk); #1;
    rst = 1'b1; mem_rd_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (sram_rd_en !== 1'b0 || sram_wr_en !== 1'b0 || ready !== 1'b0) begin
      fail_cnt++;
      $display("FAIL mid_fill_reset: got rd=%b wr=%b ready=%b expected 0 0 0", sram_rd_en, sram_wr_en, ready);
    end
    exp_hits = 0; exp_misses = 0;
    test_stats();
    @(posedge clk); #1;
    rst = 1'b0;
    cpu_read(32'h0000_0040, 1'b0);
    cpu_read(32'h0000_0240, 1'b0);
  endtask

  initial begin
    mem[32'h0000_0040] = 32'h1111_1111;
    mem[32'h0000_0044] = 32'h2222_2222;
    mem[32'h0000_0240] = 32'h3333_3333;
    mem[32'h0000_0244] = 32'h4444_4444;
    test_reset();
    test_miss_fill();
    test_hit();
    test_write_hit();
    test_conflict();
    test_no_allocate();
    test_back_to_back();
    test_stats();
    test_reset_mid_fill();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
